// File: rtl/store_commit_unit_pkg.sv
// Shared definitions for the store-commit path: op-type codes, store widths,
// FSM state encoding and the width-to-byte-count helper.
package store_commit_unit_pkg;

   localparam int XLEN    = 32;
   localparam int ENTRY_W = 6;
   localparam int OP_W    = 3;

   localparam logic             TRUE     = 1'b1;
   localparam logic             FALSE    = 1'b0;
   localparam logic [ENTRY_W-1:0] NULL_ENTRY = '0;

   localparam logic [OP_W-1:0] OP_NULL  = 3'd0;
   localparam logic [OP_W-1:0] OP_STYPE = 3'd2;

   typedef enum logic [1:0] {
      SW_BYTE = 2'd0,
      SW_HALF = 2'd1,
      SW_WORD = 2'd2
   } store_width_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // The unused width code 3 is treated as a full word.
   function automatic logic [2:0] width_bytes(input logic [1:0] width);
      case (width)
         SW_BYTE: width_bytes = 3'd1;
         SW_HALF: width_bytes = 3'd2;
         default: width_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/store_commit_unit_if.sv
// LSB resolve, ROB commit and memory-controller signals of the store-commit unit.
// The slave modport is the commit unit itself; master is its environment.
interface store_commit_unit_if;
   import store_commit_unit_pkg::*;

   logic                 lsb_store_addressed;
   logic [ENTRY_W-1:0]   lsb_store_entry;
   logic [XLEN-1:0]      lsb_store_addr;
   logic [XLEN-1:0]      lsb_store_data;
   logic [1:0]           lsb_store_width;

   logic                 rob_commit;
   logic [OP_W-1:0]      rob_op_type_commit;
   logic [ENTRY_W-1:0]   rob_entry_commit;
   logic                 finish_store;

   logic                 mem_grant;
   logic                 io_buffer_full;
   logic                 mem_req;
   logic                 mem_wr;
   logic [XLEN-1:0]      mem_a;
   logic [7:0]           mem_dout;

   modport master (
      output lsb_store_addressed, lsb_store_entry, lsb_store_addr, lsb_store_data, lsb_store_width,
      output rob_commit, rob_op_type_commit, rob_entry_commit,
      output mem_grant, io_buffer_full,
      input  finish_store, mem_req, mem_wr, mem_a, mem_dout
   );

   modport slave (
      input  lsb_store_addressed, lsb_store_entry, lsb_store_addr, lsb_store_data, lsb_store_width,
      input  rob_commit, rob_op_type_commit, rob_entry_commit,
      input  mem_grant, io_buffer_full,
      output finish_store, mem_req, mem_wr, mem_a, mem_dout
   );

endinterface

// File: rtl/store_commit_unit_store_addr_table.sv
// Per-ROB-entry table of resolved store operands. One write port (LSB), one
// read port (commit) that forwards a same-cycle write, a flush that keeps
// one slot alive, and a single-slot clear. A write always wins over clears.
module store_addr_table
   import store_commit_unit_pkg::*;
#(
   parameter int ROB_SIZE = 32,
   parameter int IDX_W    = $clog2(ROB_SIZE)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [XLEN-1:0]  wr_addr,
   input  logic [XLEN-1:0]  wr_data,
   input  logic [1:0]       wr_width,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [XLEN-1:0]  rd_addr,
   output logic [XLEN-1:0]  rd_data,
   output logic [1:0]       rd_width,
   input  logic             flush,
   input  logic             keep_en,
   input  logic [IDX_W-1:0] keep_idx,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx
);

   logic [ROB_SIZE-1:0] valid;
   logic [XLEN-1:0]     addr_mem  [ROB_SIZE];
   logic [XLEN-1:0]     data_mem  [ROB_SIZE];
   logic [1:0]          width_mem [ROB_SIZE];
   logic                bypass;

   assign bypass   = wr_en && (wr_idx == rd_idx);
   assign rd_valid = bypass || valid[rd_idx];
   assign rd_addr  = bypass ? wr_addr  : addr_mem[rd_idx];
   assign rd_data  = bypass ? wr_data  : data_mem[rd_idx];
   assign rd_width = bypass ? wr_width : width_mem[rd_idx];

   // Valid bits: flush and completion clears first, then a capture re-validates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (en) begin
         if (flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
               if (!(keep_en && (IDX_W'(i) == keep_idx))) valid[i] <= 1'b0;
            end
         end
         if (clr_en) valid[clr_idx] <= 1'b0;
         if (wr_en)  valid[wr_idx]  <= 1'b1;
      end
   end

   // Operand storage needs no reset; it is only read behind a valid bit.
   always_ff @(posedge clk) begin
      if (en && wr_en) begin
         addr_mem[wr_idx]  <= wr_addr;
         data_mem[wr_idx]  <= wr_data;
         width_mem[wr_idx] <= wr_width;
      end
   end

endmodule

// File: rtl/store_commit_unit.sv
// Store-commit responder: on a ROB store commit, streams the stored bytes to
// memory one at a time over the 8-bit port and pulses finish_store when done.
module store_commit_unit
   import store_commit_unit_pkg::*;
#(
   parameter int         ROB_SIZE = 32,
   parameter logic [1:0] IO_HI    = 2'b11
)(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               roll_back,
   output logic               busy,
   store_commit_unit_if.slave bus
);

   localparam int IDX_W = $clog2(ROB_SIZE);

   state_e           state, state_nxt;
   logic [XLEN-1:0]  cur_addr, cur_data;
   logic [2:0]       nbytes;
   logic [1:0]       k, k_nxt;
   logic [IDX_W-1:0] cur_idx;
   logic             suppress;

   logic             tbl_valid;
   logic [XLEN-1:0]  tbl_addr, tbl_data;
   logic [1:0]       tbl_width;
   logic             commit_st, fire, clr_done, io_stall;
   logic             unused_entry_bits;

   assign commit_st = bus.rob_commit && (bus.rob_op_type_commit == OP_STYPE);
   assign io_stall  = (cur_addr[17:16] == IO_HI) && bus.io_buffer_full;
   assign busy      = (state != IDLE);
   assign unused_entry_bits = ^{bus.lsb_store_entry[ENTRY_W-1:IDX_W],
                                bus.rob_entry_commit[ENTRY_W-1:IDX_W]};

   store_addr_table #(.ROB_SIZE(ROB_SIZE), .IDX_W(IDX_W)) u_table (
      .clk      (clk_in),
      .rst_n    (rst_in),
      .en       (rdy_in),
      .wr_en    (bus.lsb_store_addressed),
      .wr_idx   (bus.lsb_store_entry[IDX_W-1:0]),
      .wr_addr  (bus.lsb_store_addr),
      .wr_data  (bus.lsb_store_data),
      .wr_width (bus.lsb_store_width),
      .rd_idx   (bus.rob_entry_commit[IDX_W-1:0]),
      .rd_valid (tbl_valid),
      .rd_addr  (tbl_addr),
      .rd_data  (tbl_data),
      .rd_width (tbl_width),
      .flush    (roll_back),
      .keep_en  (busy),
      .keep_idx (cur_idx),
      .clr_en   (clr_done),
      .clr_idx  (cur_idx)
   );

   // Next-state and bus outputs; a byte is written only when granted, unpaused and not IO-stalled.
   always_comb begin
      state_nxt        = state;
      k_nxt            = k;
      fire             = 1'b0;
      clr_done         = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.mem_a        = '0;
      bus.mem_dout     = '0;
      bus.finish_store = 1'b0;
      case (state)
         IDLE: begin
            if (commit_st && tbl_valid) begin
               fire      = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            bus.mem_req = 1'b1;
            if (bus.mem_grant) state_nxt = WRITE;
         end
         WRITE: begin
            bus.mem_req  = 1'b1;
            bus.mem_a    = cur_addr + XLEN'(k);
            bus.mem_dout = cur_data[{k, 3'b000} +: 8];
            if (rdy_in && bus.mem_grant && !io_stall) begin
               bus.mem_wr = 1'b1;
               k_nxt      = k + 2'd1;
               if ({1'b0, k} == nbytes - 3'd1) state_nxt = DONE;
            end
         end
         DONE: begin
            bus.finish_store = rdy_in && !suppress && !roll_back;
            clr_done         = rdy_in;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, byte counter and latched operands; a flush while busy silences the completion pulse.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         k        <= 2'd0;
         cur_addr <= '0;
         cur_data <= '0;
         nbytes   <= 3'd0;
         cur_idx  <= '0;
         suppress <= 1'b0;
      end else if (rdy_in) begin
         state <= state_nxt;
         k     <= k_nxt;
         if (fire) begin
            cur_addr <= tbl_addr;
            cur_data <= tbl_data;
            nbytes   <= width_bytes(tbl_width);
            cur_idx  <= bus.rob_entry_commit[IDX_W-1:0];
            k        <= 2'd0;
            suppress <= 1'b0;
         end else if (roll_back && busy) begin
            suppress <= 1'b1;
         end
      end
   end

   a_commit_valid : assert property (@(posedge clk_in) disable iff (!rst_in)
      (rdy_in && state == IDLE && commit_st) |-> tbl_valid)
      else $warning("store commit to an unaddressed ROB entry was ignored");

   a_commit_idle : assert property (@(posedge clk_in) disable iff (!rst_in)
      (rdy_in && state != IDLE) |-> !commit_st)
      else $warning("store commit while busy was ignored");

endmodule

// File: tb/tb_store_commit_unit.sv
// Self-checking bench for store_commit_unit: a small operand model feeds a
// queue of expected byte writes that a monitor compares against the bus.
`timescale 1ns/1ps
module tb_store_commit_unit;
   import store_commit_unit_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   logic clk_in    = 1'b0;
   logic rst_in    = 1'b0;
   logic rdy_in    = 1'b1;
   logic roll_back = 1'b0;
   logic busy;

   store_commit_unit_if bus();

   store_commit_unit #(.ROB_SIZE(32), .IO_HI(2'b11)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .roll_back (roll_back),
      .busy      (busy),
      .bus       (bus)
   );

   int          checks  = 0;
   int          errors  = 0;
   int          fin_cnt = 0;
   wr_t         exp_q[$];
   logic        m_valid [32];
   logic [31:0] m_addr  [32];
   logic [31:0] m_data  [32];
   logic [1:0]  m_width [32];

   // Free-running 100 MHz clock
   always #5 clk_in = ~clk_in;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void push_bytes(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] width);
      wr_t e;
      int  n;
      n = (width == SW_BYTE) ? 1 : (width == SW_HALF) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
         e.a = addr + 32'(i);
         e.d = data[8*i +: 8];
         exp_q.push_back(e);
      end
   endfunction

   function automatic void model_flush(input int keep);
      for (int i = 0; i < 32; i++) if (i != keep) m_valid[i] = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Drives one cycle of LSB capture and/or ROB commit, updating the model and scoreboard
   task automatic apply_stimulus(input bit do_addr, input logic [5:0] a_entry,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] width, input bit do_commit,
                                 input logic [5:0] c_entry);
      int ci;
      int ai;
      ci = int'(c_entry[4:0]);
      ai = int'(a_entry[4:0]);
      bus.lsb_store_addressed = do_addr;
      bus.lsb_store_entry     = a_entry;
      bus.lsb_store_addr      = addr;
      bus.lsb_store_data      = data;
      bus.lsb_store_width     = width;
      bus.rob_commit          = do_commit;
      bus.rob_op_type_commit  = do_commit ? OP_STYPE : OP_NULL;
      bus.rob_entry_commit    = c_entry;
      if (do_commit) begin
         if (do_addr && ai == ci) push_bytes(addr, data, width);
         else if (m_valid[ci])    push_bytes(m_addr[ci], m_data[ci], m_width[ci]);
      end
      if (do_addr) begin
         m_valid[ai] = 1'b1;
         m_addr[ai]  = addr;
         m_data[ai]  = data;
         m_width[ai] = width;
      end
      tick();
      bus.lsb_store_addressed = 1'b0;
      bus.rob_commit          = 1'b0;
      bus.rob_op_type_commit  = OP_NULL;
   endtask

   task automatic wait_finish(input string tag, output int cyc);
      cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_in);
         if (bus.finish_store) begin
            cyc = c;
            break;
         end
      end
      if (cyc < 0) check_output({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic count_req(input int n, output int req_cnt);
      req_cnt = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk_in);
         if (bus.mem_req) req_cnt++;
      end
   endtask

   // Byte-write monitor: every observed write must match the head of the expected queue
   always @(negedge clk_in) begin
      wr_t e;
      if (rst_in && bus.mem_wr) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_wr", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_output("wr_addr", bus.mem_a, e.a);
            check_output("wr_data", {24'd0, bus.mem_dout}, {24'd0, e.d});
         end
      end
   end

   // Completion pulse counter
   always @(negedge clk_in) begin
      if (rst_in && bus.finish_store) fin_cnt++;
   end

   // Global time limit
   initial begin
      #200000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence of directed scenarios
   initial begin
      int cyc, wc, fc, fin_before, req_cnt;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      bus.lsb_store_addressed = 1'b0;
      bus.lsb_store_entry     = '0;
      bus.lsb_store_addr      = '0;
      bus.lsb_store_data      = '0;
      bus.lsb_store_width     = '0;
      bus.rob_commit          = 1'b0;
      bus.rob_op_type_commit  = OP_NULL;
      bus.rob_entry_commit    = '0;
      bus.mem_grant           = 1'b1;
      bus.io_buffer_full      = 1'b0;

      #3;
      check_output("rst_req",    32'(bus.mem_req),      32'd0);
      check_output("rst_wr",     32'(bus.mem_wr),       32'd0);
      check_output("rst_finish", 32'(bus.finish_store), 32'd0);
      check_output("rst_a",      bus.mem_a,             32'd0);
      check_output("rst_dout",   32'(bus.mem_dout),     32'd0);
      check_output("rst_busy",   32'(busy),             32'd0);
      tick();
      rst_in = 1'b1;
      tick();

      $display("[TB] word store, grant held high");
      apply_stimulus(1, 6'd5, 32'h0000_1000, 32'hDEAD_BEEF, SW_WORD, 0, 6'd0);
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd5);
      wait_finish("sw", cyc);
      check_output("sw_latency", 32'(cyc), 32'd6);
      m_valid[5] = 1'b0;
      check_output("sw_drain", 32'(exp_q.size()), 32'd0);
      tick();
      check_output("sw_idle", 32'(busy), 32'd0);

      $display("[TB] byte store to IO with full buffer");
      apply_stimulus(1, 6'd2, 32'h0003_0000, 32'h0000_0041, SW_BYTE, 0, 6'd0);
      bus.io_buffer_full = 1'b1;
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd2);
      repeat (3) begin
         @(negedge clk_in);
         check_output("io_stall_wr",  32'(bus.mem_wr),  32'd0);
         check_output("io_stall_req", 32'(bus.mem_req), 32'd1);
      end
      @(posedge clk_in);
      #1;
      bus.io_buffer_full = 1'b0;
      wc = -1;
      fc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_in);
         if (bus.mem_wr && wc < 0) wc = c;
         if (bus.finish_store) begin
            fc = c;
            break;
         end
      end
      check_output("io_wr_after_release", 32'(wc), 32'd1);
      check_output("io_finish_gap", 32'(fc - wc), 32'd1);
      m_valid[2] = 1'b0;
      check_output("io_drain", 32'(exp_q.size()), 32'd0);
      tick();

      $display("[TB] misaligned half store with grant dropped");
      apply_stimulus(1, 6'd4, 32'h0000_2001, 32'h0000_1234, SW_HALF, 0, 6'd0);
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd4);
      tick();
      tick();
      bus.mem_grant = 1'b0;
      @(negedge clk_in);
      check_output("sh_nogrant_wr",  32'(bus.mem_wr),  32'd0);
      check_output("sh_nogrant_req", 32'(bus.mem_req), 32'd1);
      @(posedge clk_in);
      #1;
      bus.mem_grant = 1'b1;
      wait_finish("sh", cyc);
      check_output("sh_finish", 32'(cyc), 32'd2);
      m_valid[4] = 1'b0;
      check_output("sh_drain", 32'(exp_q.size()), 32'd0);
      tick();

      $display("[TB] same-cycle capture and commit on entry 31");
      apply_stimulus(1, 6'd31, 32'h0000_4000, 32'hCAFE_F00D, SW_HALF, 1, 6'd31);
      wait_finish("byp", cyc);
      check_output("byp_latency", 32'(cyc), 32'd4);
      m_valid[31] = 1'b0;
      check_output("byp_drain", 32'(exp_q.size()), 32'd0);
      tick();

      $display("[TB] flush during word write");
      apply_stimulus(1, 6'd7, 32'h0000_5000, 32'h1122_3344, SW_WORD, 0, 6'd0);
      apply_stimulus(1, 6'd9, 32'h0000_6000, 32'h5566_7788, SW_WORD, 0, 6'd0);
      fin_before = fin_cnt;
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd7);
      tick();
      roll_back = 1'b1;
      model_flush(7);
      tick();
      roll_back = 1'b0;
      repeat (10) @(negedge clk_in);
      tick();
      check_output("rb_no_finish", 32'(fin_cnt - fin_before), 32'd0);
      check_output("rb_idle", 32'(busy), 32'd0);
      check_output("rb_drain", 32'(exp_q.size()), 32'd0);
      m_valid[7] = 1'b0;
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd9);
      count_req(8, req_cnt);
      check_output("rb_flushed_req", 32'(req_cnt), 32'd0);
      check_output("rb_flushed_busy", 32'(busy), 32'd0);
      tick();

      $display("[TB] reset during write");
      apply_stimulus(1, 6'd3, 32'h0000_7000, 32'hA5A5_A5A5, SW_WORD, 0, 6'd0);
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd3);
      tick();
      check_output("pre_reset_wr", 32'(bus.mem_wr), 32'd1);
      #2;
      rst_in = 1'b0;
      #1;
      check_output("arst_req",    32'(bus.mem_req),      32'd0);
      check_output("arst_wr",     32'(bus.mem_wr),       32'd0);
      check_output("arst_a",      bus.mem_a,             32'd0);
      check_output("arst_dout",   32'(bus.mem_dout),     32'd0);
      check_output("arst_finish", 32'(bus.finish_store), 32'd0);
      check_output("arst_busy",   32'(busy),             32'd0);
      exp_q.delete();
      model_flush(-1);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      tick();
      apply_stimulus(0, 6'd0, 32'd0, 32'd0, SW_BYTE, 1, 6'd3);
      count_req(8, req_cnt);
      check_output("post_rst_req", 32'(req_cnt), 32'd0);
      check_output("post_rst_busy", 32'(busy), 32'd0);
      check_output("final_drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
